// File: rtl/ahb_arbiter.sv
// Two-master AHB-Lite arbiter: round-robin grant, burst/lock hold,
// default-master parking and HREADY-qualified HMASTER handover.
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_MASTER_BITS
`define AHB_MASTER_BITS 2
`endif

module ahb_arbiter #(
  parameter bit PARK_LAST = 1'b0,
  parameter int RR_INIT   = 1
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic                        HBUSREQ_M1,
  input  logic                        HBUSREQ_M2,
  input  logic                        HLOCK_M1,
  input  logic                        HLOCK_M2,
  input  logic [`AHB_TRANS_BITS-1:0]  HTRANS,
  input  logic [2:0]                  HBURST,
  input  logic                        HREADY,
  output logic                        HGRANT_M1,
  output logic                        HGRANT_M2,
  output logic [`AHB_MASTER_BITS-1:0] HMASTER,
  output logic                        HMASTLOCK
);

  localparam int TW = `AHB_TRANS_BITS;
  localparam int MW = `AHB_MASTER_BITS;

  localparam logic [TW-1:0] TR_IDLE   = TW'(0);
  localparam logic [TW-1:0] TR_NONSEQ = TW'(2);
  localparam logic [TW-1:0] TR_SEQ    = TW'(3);

  typedef enum logic [MW-1:0] {
    GNT_DEF = MW'(0),
    GNT_M1  = MW'(1),
    GNT_M2  = MW'(2)
  } gnt_e;

  gnt_e          r_grant;
  gnt_e          w_gnt_nxt;
  logic          r_prio2;
  logic [3:0]    r_beat_cnt;
  logic [3:0]    w_cnt_nxt;
  logic [3:0]    w_burst_len;
  logic [MW-1:0] r_hmaster;
  logic          r_mastlock;
  logic          w_cur_lock;
  logic          w_open;

  always_comb begin
    w_burst_len = 4'd0;
    case (HBURST)
      3'd2, 3'd3: w_burst_len = 4'd3;
      3'd4, 3'd5: w_burst_len = 4'd7;
      3'd6, 3'd7: w_burst_len = 4'd15;
      default:    w_burst_len = 4'd0;
    endcase
  end

  // Remaining-beat count after this edge's transfer is accepted.
  always_comb begin
    w_cnt_nxt = r_beat_cnt;
    if (HREADY) begin
      case (HTRANS)
        TR_NONSEQ: w_cnt_nxt = w_burst_len;
        TR_SEQ: begin
          if (r_beat_cnt != 4'd0)
            w_cnt_nxt = r_beat_cnt - 4'd1;
        end
        TR_IDLE: w_cnt_nxt = 4'd0;
        default: w_cnt_nxt = r_beat_cnt;
      endcase
    end
  end

  always_comb begin
    w_cur_lock = 1'b0;
    unique case (1'b1)
      (r_grant == GNT_M1): w_cur_lock = HLOCK_M1;
      (r_grant == GNT_M2): w_cur_lock = HLOCK_M2;
      default:             w_cur_lock = 1'b0;
    endcase
  end

  // Arbitrating on the updated count lets the grant move while the
  // final beat's address phase is on the bus, not one beat later.
  assign w_open = (w_cnt_nxt <= 4'd1) && !w_cur_lock;

  always_comb begin
    w_gnt_nxt = r_grant;
    if (w_open) begin
      if (HBUSREQ_M1 && HBUSREQ_M2)
        w_gnt_nxt = r_prio2 ? GNT_M2 : GNT_M1;
      else if (HBUSREQ_M1)
        w_gnt_nxt = GNT_M1;
      else if (HBUSREQ_M2)
        w_gnt_nxt = GNT_M2;
      else if (!PARK_LAST)
        w_gnt_nxt = GNT_DEF;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_grant    <= GNT_DEF;
      r_prio2    <= (RR_INIT == 2);
      r_beat_cnt <= 4'd0;
    end else begin
      r_grant    <= w_gnt_nxt;
      r_beat_cnt <= w_cnt_nxt;
      if (w_gnt_nxt != r_grant) begin
        if (w_gnt_nxt == GNT_M1)
          r_prio2 <= 1'b1;
        else if (w_gnt_nxt == GNT_M2)
          r_prio2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_hmaster  <= '0;
      r_mastlock <= 1'b0;
    end else if (HREADY) begin
      r_hmaster  <= r_grant;
      r_mastlock <= w_cur_lock;
    end
  end

  assign HGRANT_M1 = (r_grant == GNT_M1);
  assign HGRANT_M2 = (r_grant == GNT_M2);
  assign HMASTER   = r_hmaster;
  assign HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: vector table plus hand sequences
// for lock, early burst termination, async reset and parking.
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_MASTER_BITS
`define AHB_MASTER_BITS 2
`endif

module tb_ahb_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       breq1, breq2, lock1, lock2;
  logic [`AHB_TRANS_BITS-1:0] htrans;
  logic [2:0] hburst;
  logic       hready;

  logic       g1_0, g2_0, ml_0;
  logic [`AHB_MASTER_BITS-1:0] hm_0;
  logic       g1_1, g2_1, ml_1;
  logic [`AHB_MASTER_BITS-1:0] hm_1;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_arbiter #(.PARK_LAST(1'b0), .RR_INIT(1)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET),
    .HBUSREQ_M1(breq1), .HBUSREQ_M2(breq2),
    .HLOCK_M1(lock1), .HLOCK_M2(lock2),
    .HTRANS(htrans), .HBURST(hburst), .HREADY(hready),
    .HGRANT_M1(g1_0), .HGRANT_M2(g2_0),
    .HMASTER(hm_0), .HMASTLOCK(ml_0)
  );

  ahb_arbiter #(.PARK_LAST(1'b1), .RR_INIT(1)) dut1 (
    .HCLK(HCLK), .HRESET(HRESET),
    .HBUSREQ_M1(breq1), .HBUSREQ_M2(breq2),
    .HLOCK_M1(lock1), .HLOCK_M2(lock2),
    .HTRANS(htrans), .HBURST(hburst), .HREADY(hready),
    .HGRANT_M1(g1_1), .HGRANT_M2(g2_1),
    .HMASTER(hm_1), .HMASTLOCK(ml_1)
  );

  typedef struct {
    logic       b1, b2, l1, l2;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       rd;
    logic       e1, e2;
    logic [1:0] ehm;
    logic       eml;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t v(
    input logic b1, b2, l1, l2,
    input logic [1:0] tr, input logic [2:0] bu, input logic rd,
    input logic e1, e2, input logic [1:0] ehm, input logic eml);
    vec_t r;
    r.b1 = b1; r.b2 = b2; r.l1 = l1; r.l2 = l2;
    r.tr = tr; r.bu = bu; r.rd = rd;
    r.e1 = e1; r.e2 = e2; r.ehm = ehm; r.eml = eml;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic b1, b2, l1, l2,
                       input logic [1:0] tr, input logic [2:0] bu,
                       input logic rd);
    breq1 = b1; breq2 = b2; lock1 = l1; lock2 = l2;
    htrans = tr; hburst = bu; hready = rd;
  endtask

  task automatic chk_all(input string nm, input logic e1, e2,
                         input logic [1:0] ehm, input logic eml);
    chk({nm, ".g1"}, {7'd0, g1_0}, {7'd0, e1});
    chk({nm, ".g2"}, {7'd0, g2_0}, {7'd0, e2});
    chk({nm, ".hm"}, {6'd0, hm_0}, {6'd0, ehm});
    chk({nm, ".ml"}, {7'd0, ml_0}, {7'd0, eml});
  endtask

  initial begin
    // idle / M1 request / drop
    tbl[0]  = v(0,0,0,0, 2'd0,3'd0,1, 0,0,2'd0,0);
    tbl[1]  = v(0,0,0,0, 2'd0,3'd0,1, 0,0,2'd0,0);
    tbl[2]  = v(1,0,0,0, 2'd0,3'd0,1, 1,0,2'd0,0);
    tbl[3]  = v(1,0,0,0, 2'd0,3'd0,1, 1,0,2'd1,0);
    tbl[4]  = v(0,0,0,0, 2'd0,3'd0,1, 0,0,2'd1,0);
    tbl[5]  = v(0,0,0,0, 2'd0,3'd0,1, 0,0,2'd0,0);
    // M1 regains, then INCR4 with M2 requesting
    tbl[6]  = v(1,0,0,0, 2'd0,3'd0,1, 1,0,2'd0,0);
    tbl[7]  = v(1,0,0,0, 2'd0,3'd0,1, 1,0,2'd1,0);
    tbl[8]  = v(1,1,0,0, 2'd2,3'd3,1, 1,0,2'd1,0);
    tbl[9]  = v(1,1,0,0, 2'd3,3'd3,1, 1,0,2'd1,0);
    tbl[10] = v(1,1,0,0, 2'd3,3'd3,1, 0,1,2'd1,0);
    tbl[11] = v(0,1,0,0, 2'd3,3'd3,1, 0,1,2'd2,0);
    // round robin on SINGLE transfers
    tbl[12] = v(1,1,0,0, 2'd2,3'd0,1, 1,0,2'd2,0);
    tbl[13] = v(1,1,0,0, 2'd2,3'd0,1, 0,1,2'd1,0);
    tbl[14] = v(1,1,0,0, 2'd2,3'd0,1, 1,0,2'd2,0);
    tbl[15] = v(1,1,0,0, 2'd2,3'd0,1, 0,1,2'd1,0);
    tbl[16] = v(0,0,0,0, 2'd0,3'd0,1, 0,0,2'd2,0);
    tbl[17] = v(0,0,0,0, 2'd0,3'd0,1, 0,0,2'd0,0);

    HRESET = 1'b1;
    drive(0,0,0,0, 2'd0,3'd0,1);
    repeat (2) tick();
    chk_all("rst", 0, 0, 2'd0, 0);
    HRESET = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].b1, tbl[i].b2, tbl[i].l1, tbl[i].l2,
            tbl[i].tr, tbl[i].bu, tbl[i].rd);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e1, tbl[i].e2,
              tbl[i].ehm, tbl[i].eml);
    end

    // locked sequence by M2
    drive(0,1,0,1, 2'd0,3'd0,1);
    tick();
    chk("lk.grant", {7'd0, g2_0}, 8'd1);
    drive(1,1,0,1, 2'd0,3'd0,1);
    tick();
    chk_all("lk.own", 0, 1, 2'd2, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all($sformatf("lk.hold%0d", i), 0, 1, 2'd2, 1);
    end
    drive(1,1,0,0, 2'd0,3'd0,1);
    tick();
    chk("lk.rel.g1", {7'd0, g1_0}, 8'd1);
    chk("lk.rel.g2", {7'd0, g2_0}, 8'd0);
    drive(1,0,0,0, 2'd0,3'd0,1);
    tick();
    chk_all("lk.after", 1, 0, 2'd1, 0);

    // park, then M1 owns again
    drive(0,0,0,0, 2'd0,3'd0,1);
    repeat (2) tick();
    chk_all("park0", 0, 0, 2'd0, 0);
    drive(1,0,0,0, 2'd0,3'd0,1);
    repeat (2) tick();
    chk_all("m1own", 1, 0, 2'd1, 0);

    // INCR8 cut short by IDLE, then stalled handover
    drive(1,1,0,0, 2'd2,3'd5,1);
    tick();
    chk_all("i8.b1", 1, 0, 2'd1, 0);
    drive(1,1,0,0, 2'd3,3'd5,1);
    tick();
    chk_all("i8.b2", 1, 0, 2'd1, 0);
    tick();
    chk_all("i8.b3", 1, 0, 2'd1, 0);
    drive(0,1,0,0, 2'd0,3'd5,1);
    tick();
    chk_all("i8.idle", 0, 1, 2'd1, 0);
    drive(0,1,0,0, 2'd0,3'd5,0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("i8.stall%0d", i), 0, 1, 2'd1, 0);
    end
    drive(0,1,0,0, 2'd0,3'd5,1);
    tick();
    chk_all("i8.hand", 0, 1, 2'd2, 0);

    // async reset in the middle of an INCR16
    drive(1,1,0,0, 2'd2,3'd7,1);
    tick();
    chk_all("i16.b1", 0, 1, 2'd2, 0);
    #3 HRESET = 1'b1;
    #1 chk_all("arst", 0, 0, 2'd0, 0);
    #2 HRESET = 1'b0;
    drive(1,1,0,0, 2'd3,3'd7,1);
    tick();
    chk_all("arst.cnt", 1, 0, 2'd0, 0);

    // PARK_LAST=1 keeps the last owner
    drive(1,0,0,0, 2'd0,3'd0,1);
    tick();
    drive(0,0,0,0, 2'd0,3'd0,1);
    tick();
    chk("pl0.g1", {7'd0, g1_0}, 8'd0);
    chk("pl1.g1", {7'd0, g1_1}, 8'd1);
    tick();
    chk("pl0.hm", {6'd0, hm_0}, 8'd0);
    chk("pl1.hm", {6'd0, hm_1}, 8'd1);
    chk("pl1.g2", {7'd0, g2_1}, 8'd0);
    chk("pl1.ml", {7'd0, ml_1}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
Two-master AHB-Lite bus arbiter sitting directly upstream of the master-to-slave multiplexer. Owns HMASTER, the select that the mux registers on HREADY, plus per-master HGRANT and HMASTLOCK. Round-robin between M1 and M2, holds ownership across fixed-length bursts and locked sequences, and parks on the default master (ID 0) when idle.

Parameters:
PARK_LAST, 0, 0 = grant returns to default master 0 when no requests; 1 = grant stays with last owner
RR_INIT, 1, master ID (1 or 2) holding highest priority after reset

Ports:
HCLK  input  1  bus clock
HRESET  input  1  asynchronous active-high reset
HBUSREQ_M1  input  1  bus request, master 1
HBUSREQ_M2  input  1  bus request, master 2
HLOCK_M1  input  1  locked-transfer request, master 1
HLOCK_M2  input  1  locked-transfer request, master 2
HTRANS  input  `AHB_TRANS_BITS  muxed transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
HBURST  input  3  muxed burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
HREADY  input  1  transfer accept / handover strobe
HGRANT_M1  output  1  grant, master 1 (registered)
HGRANT_M2  output  1  grant, master 2 (registered)
HMASTER  output  `AHB_MASTER_BITS  current address-phase owner (0 = default, 1, 2)
HMASTLOCK  output  1  current owner performing a locked sequence

Behaviour:
- Reset (async, immediate): grant_id=0, HGRANT_M1=HGRANT_M2=0, HMASTER=0, HMASTLOCK=0, beat_cnt=0, priority pointer=RR_INIT.
- grant_id register (0/1/2); HGRANT_Mx = (grant_id==x); at most one grant high.
- HMASTER <= grant_id on HCLK edge with HREADY=1; holds otherwise. Handover latency: request -> HGRANT 1 cycle (if arbitration open) -> HMASTER on next HREADY edge.
- HMASTLOCK <= HLOCK of grant_id master (0 if grant_id=0) on HCLK edge with HREADY=1.
- Burst tracking (on accepted transfers, HREADY=1):
  - HTRANS=NONSEQ: beat_cnt <= 3/7/15 for 4/8/16-beat bursts, 0 for SINGLE/INCR.
  - HTRANS=SEQ and beat_cnt>0: beat_cnt <= beat_cnt-1.
  - HTRANS=IDLE: beat_cnt <= 0 (early termination).
  - BUSY: no change.
- Arbitration open when beat_cnt<=1 AND HLOCK of current grant_id master is 0. beat_cnt==1 is open so the grant can move during the last beat's address phase.
- Closed: grant_id holds, regardless of requests or request deassertion.
- Open, each HCLK edge (independent of HREADY):
  - Both request: grant highest-priority master.
  - One requests: grant it.
  - None: grant_id <= 0 (PARK_LAST=0) or hold (PARK_LAST=1).
- Priority: when grant_id changes to master x (1/2), the other master becomes highest priority. Parking on 0 does not move the pointer.
- Current owner still requesting with the other master also requesting and arbitration open: round-robin applies, so the owner loses if it holds lower priority.
- HREADY low for many cycles: grant may change again before handover; HMASTER takes only the grant_id present at the HREADY edge.

Test Plan:
- Reset then idle, no requests -> HGRANT_M1=HGRANT_M2=0, HMASTER=0, HMASTLOCK=0 throughout; async HRESET pulse mid-burst clears all outputs and beat_cnt the same cycle.
- HBUSREQ_M1=1 at cycle 0, HREADY=1 -> HGRANT_M1=1 after edge 1, HMASTER=1 after edge 2; drop request -> HGRANT_M1=0 next edge, HMASTER=0 edge after (PARK_LAST=0); with PARK_LAST=1 grant and HMASTER remain 1.
- M1 owns, issues INCR4 (NONSEQ, SEQ, SEQ, SEQ, HREADY=1) while HBUSREQ_M2=1 from the first beat -> HGRANT_M1 held through beat 3, HGRANT_M2=1 after the 3rd-beat edge (beat_cnt=1), HMASTER=2 after the 4th-beat edge.
- Both request continuously, SINGLE transfers, RR_INIT=1 -> grant alternates 1,2,1,2 each arbitration.
- M2 owns with HLOCK_M2=1, HBUSREQ_M1=1 for 10 cycles -> HGRANT_M2 held, HMASTLOCK=1; HLOCK_M2 drops -> HGRANT_M1=1 next edge, HMASTLOCK=0 on following HREADY edge.
- INCR8 by M1 terminated by IDLE after 3 beats with M2 requesting -> beat_cnt=0, grant moves to M2 next edge; HREADY held low 3 cycles -> HMASTER stays 1 until HREADY=1 edge, then 2.
